// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable delay controller.
package delay_pkg;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  // Width of a field able to hold every delay value 0..max_delay.
  function automatic int calc_dw(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/delay_ctrl_if.sv
// Config handshake and data stream bundle of delay_ctrl.
interface delay_ctrl_if #(
  parameter int N         = 3,
  parameter int MAX_DELAY = 8
);
  import delay_pkg::*;

  localparam int DW = calc_dw(MAX_DELAY);

  logic          cfg_valid;
  logic [DW-1:0] cfg_delay;
  logic          cfg_ready;
  logic          cfg_err;
  logic          in_valid;
  logic [N-1:0]  idata;
  logic [N-1:0]  odata;
  logic          out_valid;
  logic          busy;

  modport master (
    output cfg_valid, cfg_delay, in_valid, idata,
    input  cfg_ready, cfg_err, odata, out_valid, busy
  );

  modport slave (
    input  cfg_valid, cfg_delay, in_valid, idata,
    output cfg_ready, cfg_err, odata, out_valid, busy
  );

endinterface

// File: rtl/delay_tap_line.sv
// Tagged shift register with a selectable output tap.
module delay_tap_line
  import delay_pkg::*;
#(
  parameter int N           = 3,
  parameter int MAX_DELAY   = 8,
  localparam int DW         = calc_dw(MAX_DELAY)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [N-1:0]  idata,
  input  logic [DW-1:0] tap_sel,
  output logic [N-1:0]  odata,
  output logic          otag
);

  logic [N-1:0]         data [MAX_DELAY];
  logic [MAX_DELAY-1:0] tag;

  // Words shift every cycle; the tag records whether the word was qualified.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        data[k] <= '0;
      end
      tag <= '0;
    end else begin
      data[0] <= idata;
      tag[0]  <= in_valid;
      for (int k = 1; k < MAX_DELAY; k++) begin
        data[k] <= data[k-1];
        tag[k]  <= tag[k-1];
      end
    end
  end

  always_comb begin
    odata = '0;
    otag  = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (tap_sel == DW'(k)) begin
        odata = data[k];
        otag  = tag[k];
      end
    end
  end

endmodule

// File: rtl/delay_ctrl.sv
// Runtime-configurable delay controller: flushes and refills the tap line
// on every accepted delay change so stale words never reach the consumer.
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int N             = 3,
  parameter int MAX_DELAY     = 8,
  parameter int DEFAULT_DELAY = 4,
  localparam int DW           = calc_dw(MAX_DELAY)
) (
  input  logic       clk,
  input  logic       rst,
  delay_ctrl_if.slave bus
);

  state_t        state;
  logic [DW-1:0] dly;
  logic [DW-1:0] cnt;
  logic          busy_q;
  logic          ready_q;
  logic          err_q;

  logic          xfer;
  logic          legal;
  logic          clr;
  logic          otag;
  logic [DW-1:0] tap_sel;

  assign xfer    = bus.cfg_valid && ready_q;
  assign legal   = (bus.cfg_delay != '0) && (bus.cfg_delay <= DW'(MAX_DELAY));
  assign clr     = rst || (xfer && legal);
  assign tap_sel = dly - DW'(1);

  // A legal request restarts FILL; an illegal one only raises a one-cycle error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      dly     <= DW'(DEFAULT_DELAY);
      cnt     <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (xfer) begin
        if (legal) begin
          state   <= FILL;
          dly     <= bus.cfg_delay;
          cnt     <= '0;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        case (state)
          FILL: begin
            if (cnt == dly - DW'(1)) begin
              state   <= RUN;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              cnt <= cnt + DW'(1);
            end
          end
          RUN: begin
            state <= RUN;
          end
          default: begin
            state <= FILL;
          end
        endcase
      end
    end
  end

  delay_tap_line #(
    .N         (N),
    .MAX_DELAY (MAX_DELAY)
  ) u_tap_line (
    .clk      (clk),
    .clr      (clr),
    .in_valid (bus.in_valid),
    .idata    (bus.idata),
    .tap_sel  (tap_sel),
    .odata    (bus.odata),
    .otag     (otag)
  );

  assign bus.out_valid = otag && (state == RUN);
  assign bus.busy      = busy_q;
  assign bus.cfg_ready = ready_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: directed ramp scenarios followed by
// random traffic, all compared against a cycle-history reference model.
module tb_delay_ctrl;

  localparam int N       = 3;
  localparam int MAXD    = 8;
  localparam int DEFD    = 4;
  localparam int HIST    = 4096;

  logic clk;
  logic rst;

  delay_ctrl_if #(.N(N), .MAX_DELAY(MAXD)) bus ();

  delay_ctrl #(
    .N             (N),
    .MAX_DELAY     (MAXD),
    .DEFAULT_DELAY (DEFD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   errors;
  int   t;
  int   ramp;

  // Reference model: delay, remaining FILL cycles, first cycle whose word
  // survived the last flush, pending error pulse, and the full input history.
  int   mD;
  int   mFill;
  int   mFirst;
  int   mErr;
  bit   modelKnown;
  logic [N-1:0] histData [HIST];
  bit           histValid [HIST];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d",
               tag, t, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic cv, input logic [3:0] cd,
                               input logic iv, input logic [N-1:0] id);
    int          src;
    bit          inRange;
    logic        expTag;
    logic [N-1:0] expData;
    @(posedge clk);
    #1;
    if (modelKnown) begin
      src     = t - mD;
      inRange = (src >= 0) && (src >= mFirst);
      expTag  = inRange ? histValid[src] : 1'b0;
      expData = inRange ? histData[src] : '0;
      checkOutput("busy",      32'(bus.busy),      32'(mFill > 0));
      checkOutput("cfg_ready", 32'(bus.cfg_ready), 32'(mFill == 0));
      checkOutput("cfg_err",   32'(bus.cfg_err),   32'(mErr));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(expTag && (mFill == 0)));
      checkOutput("odata",     32'(bus.odata),     32'(expData));
    end
    rst           = r;
    bus.cfg_valid = cv;
    bus.cfg_delay = cd;
    bus.in_valid  = iv;
    bus.idata     = id;
    histData[t]   = id;
    histValid[t]  = iv;
    mErr = 0;
    if (r) begin
      mD         = DEFD;
      mFill      = DEFD;
      mFirst     = t + 1;
      modelKnown = 1'b1;
    end else if (cv && (mFill == 0)) begin
      if ((cd >= 1) && (cd <= MAXD)) begin
        mD     = int'(cd);
        mFill  = int'(cd);
        mFirst = t + 1;
      end else begin
        mErr = 1;
      end
    end else if (mFill > 0) begin
      mFill--;
    end
    t++;
  endtask

  task automatic rampCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, N'(ramp));
      ramp++;
    end
  endtask

  task automatic rampCfg(input logic [3:0] cd);
    applyStimulus(1'b0, 1'b1, cd, 1'b1, N'(ramp));
    ramp++;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    t             = 0;
    ramp          = 0;
    mD            = DEFD;
    mFill         = DEFD;
    mFirst        = 0;
    mErr          = 0;
    modelKnown    = 1'b0;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_delay = '0;
    bus.in_valid  = 1'b0;
    bus.idata     = '0;

    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, '0);

    $display("[TB] reset release and default-delay ramp");
    rampCycles(16);

    $display("[TB] reconfigure to delay 2");
    rampCfg(4'd2);
    rampCycles(10);

    $display("[TB] back to delay 4, then illegal requests 0 and 9");
    rampCfg(4'd4);
    rampCycles(8);
    rampCfg(4'd0);
    rampCycles(2);
    rampCfg(4'd9);
    rampCycles(6);

    $display("[TB] one-cycle in_valid gap");
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, N'(ramp));
    ramp++;
    rampCycles(8);

    $display("[TB] reset during FILL of delay 8");
    rampCfg(4'd8);
    rampCycles(2);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, N'(ramp));
    ramp++;
    rampCycles(10);

    $display("[TB] delay 1 then delay 8 with cfg_valid held through FILL");
    rampCfg(4'd1);
    rampCfg(4'd8);
    rampCfg(4'd8);
    rampCycles(24);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                    N'($urandom));
    end
    rampCycles(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
